// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end with a 2-slot in-order request/response buffer.
//
// Sequential fetch from a PC register. At most two slots exist, and each one is either
// in flight at memory or holding a fetched word. A redirect (pc_sel) empties the buffer.
// Responses still owed by memory are then counted in drop_q and discarded in FLUSH.
//
// Optional feature: define FETCH_MISALIGN_TRAP_EN to turn a redirect to a non-word-aligned
// target into a single trap-marker entry (if_misalign=1, if_instr=NOP) once the drain
// finishes. After that entry is accepted, fetch stays idle until the next redirect.
// Without the macro, the low two target bits are cleared and if_misalign is tied low.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   pc_sel            redirect request from the branch controller
//   target_addr       redirect destination
//   imem_req_valid    request valid to instruction memory
//   imem_req_ready    memory accepts the request
//   imem_addr         request word address (pc_q)
//   imem_rsp_valid    in-order response valid
//   imem_rsp_data     response instruction word
//   if_valid          entry presented to decode
//   if_ready          decode accepts the entry
//   if_pc, if_instr   PC and instruction of the presented entry
//   if_misalign       presented entry is a misaligned-target trap marker
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_sel,
    input  logic [31:0] target_addr,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_misalign
);

    localparam logic [31:0] NopInstr = 32'h0000_0013;

    typedef enum logic [2:0] {StBoot, StRun, StFlush, StTrap, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        head_q, head_d;
    logic [1:0]  cnt_q, cnt_d;      // slots allocated: in flight + buffered
    logic [1:0]  nfill_q, nfill_d;  // allocated slots that already hold a response
    logic [1:0]  drop_q, drop_d;    // stale responses still to be discarded
    logic [31:0] trap_pc_q, trap_pc_d;
    logic        trap_pend_q, trap_pend_d;
    logic [31:0] slot_pc_q    [2];
    logic [31:0] slot_instr_q [2];

    logic        req_fire;
    logic        rsp_take;
    logic        pop;
    logic        alloc_idx;
    logic        fill_idx;
    logic        tgt_misalign;
    logic [31:0] tgt_pc;
    logic [1:0]  owed;
    logic [1:0]  new_drop;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign tgt_misalign = (target_addr[1:0] != 2'b00);
    assign tgt_pc       = target_addr;
`else
    assign tgt_misalign = 1'b0;
    assign tgt_pc       = {target_addr[31:2], 2'b00};
`endif

    // Outputs
    always_comb begin
        imem_req_valid = (state_q == StRun) && (cnt_q < 2'd2);
        imem_addr      = pc_q;
        if (state_q == StTrap) begin
            if_valid = 1'b1;
            if_pc    = trap_pc_q;
            if_instr = NopInstr;
        end else begin
            if_valid = (state_q == StRun) && (nfill_q != 2'd0);
            if_pc    = slot_pc_q[head_q];
            if_instr = slot_instr_q[head_q];
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        if_misalign = (state_q == StTrap);
`else
        if_misalign = 1'b0;
`endif
    end

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign pop       = if_valid && if_ready && (state_q == StRun);
    assign rsp_take  = imem_rsp_valid && (state_q == StRun) && (nfill_q < cnt_q);
    // Slots fill in allocation order, so both indices are offsets from the head.
    assign alloc_idx = head_q ^ cnt_q[0];
    assign fill_idx  = head_q ^ nfill_q[0];

    // Responses still owed by memory after this edge. A response arriving now settles one
    // of them, and a request accepted now adds one. The total never exceeds 2, because
    // a request is only accepted while fewer than two slots are allocated.
    always_comb begin
        owed     = (state_q == StFlush) ? drop_q : (cnt_q - nfill_q);
        new_drop = owed + {1'b0, req_fire} - {1'b0, (imem_rsp_valid && (owed != 2'd0))};
    end

    // Next state
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        head_d      = head_q;
        cnt_d       = cnt_q;
        nfill_d     = nfill_q;
        drop_d      = drop_q;
        trap_pc_d   = trap_pc_q;
        trap_pend_d = trap_pend_q;
        if (pc_sel) begin
            // A redirect wins over any response or pop in the same cycle.
            pc_d        = tgt_pc;
            head_d      = 1'b0;
            cnt_d       = 2'd0;
            nfill_d     = 2'd0;
            drop_d      = new_drop;
            trap_pc_d   = target_addr;
            trap_pend_d = tgt_misalign;
            if (new_drop != 2'd0) begin
                state_d = StFlush;
            end else if (tgt_misalign) begin
                state_d = StTrap;
            end else begin
                state_d = StRun;
            end
        end else begin
            unique case (state_q)
                StBoot: state_d = StRun;
                StRun: begin
                    if (req_fire) begin
                        pc_d = pc_q + 32'd4;
                    end
                    cnt_d   = cnt_q + {1'b0, req_fire} - {1'b0, pop};
                    nfill_d = nfill_q + {1'b0, rsp_take} - {1'b0, pop};
                    head_d  = head_q ^ pop;
                end
                StFlush: begin
                    if (drop_q == 2'd0) begin
                        state_d = StRun;
                    end else if (imem_rsp_valid) begin
                        drop_d = drop_q - 2'd1;
                        if (drop_q == 2'd1) begin
                            state_d = trap_pend_q ? StTrap : StRun;
                        end
                    end
                end
                StTrap: begin
                    if (if_ready) begin
                        state_d = StHalt;
                    end
                end
                StHalt:  state_d = StHalt;
                default: state_d = StBoot;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= StBoot;
            pc_q            <= RESET_PC;
            head_q          <= 1'b0;
            cnt_q           <= 2'd0;
            nfill_q         <= 2'd0;
            drop_q          <= 2'd0;
            trap_pc_q       <= 32'd0;
            trap_pend_q     <= 1'b0;
            slot_pc_q[0]    <= 32'd0;
            slot_pc_q[1]    <= 32'd0;
            slot_instr_q[0] <= 32'd0;
            slot_instr_q[1] <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            head_q      <= head_d;
            cnt_q       <= cnt_d;
            nfill_q     <= nfill_d;
            drop_q      <= drop_d;
            trap_pc_q   <= trap_pc_d;
            trap_pend_q <= trap_pend_d;
            if (req_fire && !pc_sel) begin
                slot_pc_q[alloc_idx] <= pc_q;
            end
            if (rsp_take && !pc_sel) begin
                slot_instr_q[fill_idx] <= imem_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized bench for fetch_stage.
// The bench models memory as a queue of accepted requests, each tagged with the redirect
// generation it was issued in. It models the decode-side buffer as a queue of delivered
// PCs. A single negedge monitor compares the DUT against that model every cycle.
// Directed sections pin a few literal addresses and latencies taken from the monitor logs.
module tb_fetch_stage;

    localparam logic [31:0] RstPc = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pc_sel = 1'b0;
    logic [31:0] target_addr = 32'd0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misalign;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RstPc)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_sel         (pc_sel),
        .target_addr    (target_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_misalign    (if_misalign)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {
        logic [31:0] addr;
        int          gen;
    } req_t;

    req_t        inflight[$];
    logic [31:0] mbuf[$];
    int          gen = 0;
    logic [31:0] next_pc = RstPc;
    bit          trap_pend = 0;
    bit          halted = 0;
    logic [31:0] trap_pc = 32'd0;
    bit          in_reset = 1;
    int          cyc = 0;

    logic [31:0] acc_log[$];
    int          acc_cyc[$];
    logic [31:0] pres_log[$];
    logic [31:0] pres_instr[$];
    bit          pres_mis[$];
    int          pres_cyc[$];

    task automatic clear_logs();
        acc_log.delete();
        acc_cyc.delete();
        pres_log.delete();
        pres_instr.delete();
        pres_mis.delete();
        pres_cyc.delete();
    endtask

    // Monitor: compare, then advance the model with this cycle's inputs and handshakes.
    always @(negedge clk) begin
        bit   stale;
        bit   trap_act;
        bit   exp_req;
        bit   exp_ifv;
        bit   deliver;
        req_t r;
        stale = 0;
        foreach (inflight[i]) begin
            if (inflight[i].gen != gen) stale = 1;
        end
        trap_act = trap_pend && !stale;
        exp_req  = !stale && !trap_pend && !halted && ((inflight.size() + mbuf.size()) < 2);
        exp_ifv  = trap_act || (mbuf.size() > 0);

        if (in_reset) begin
            check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
            check("rst_if_valid", {31'd0, if_valid}, 32'd0);
            check("rst_if_misalign", {31'd0, if_misalign}, 32'd0);
            check("rst_if_pc", if_pc, 32'd0);
            check("rst_if_instr", if_instr, 32'd0);
        end else begin
            check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
            check("if_valid", {31'd0, if_valid}, {31'd0, exp_ifv});
            check("if_misalign", {31'd0, if_misalign}, {31'd0, trap_act});
            check("inflight_le2", {31'd0, inflight.size() <= 2}, 32'd1);
            if (exp_req) check("imem_addr", imem_addr, next_pc);
            if (trap_act) begin
                check("trap_pc", if_pc, trap_pc);
                check("trap_instr", if_instr, 32'h0000_0013);
            end else if (exp_ifv) begin
                check("if_pc", if_pc, mbuf[0]);
                check("if_instr", if_instr, instr_of(mbuf[0]));
            end
        end

        if (reset) begin
            inflight.delete();
            mbuf.delete();
            gen       = 0;
            next_pc   = RstPc;
            trap_pend = 0;
            halted    = 0;
            in_reset  = 1;
        end else begin
            in_reset = 0;
            deliver  = 0;
            if (imem_rsp_valid && inflight.size() > 0) begin
                r       = inflight.pop_front();
                deliver = (r.gen == gen) && !pc_sel;
            end
            if (imem_req_valid && imem_req_ready) begin
                inflight.push_back('{addr: imem_addr, gen: gen});
                acc_log.push_back(imem_addr);
                acc_cyc.push_back(cyc);
                next_pc = next_pc + 32'd4;
            end
            if (if_valid && if_ready && !pc_sel) begin
                pres_log.push_back(if_pc);
                pres_instr.push_back(if_instr);
                pres_mis.push_back(if_misalign);
                pres_cyc.push_back(cyc);
                if (trap_act) begin
                    trap_pend = 0;
                    halted    = 1;
                end else if (mbuf.size() > 0) begin
                    void'(mbuf.pop_front());
                end
            end
            if (deliver) mbuf.push_back(r.addr);
            if (pc_sel) begin
                gen++;
                mbuf.delete();
                halted = 0;
                clear_logs();
`ifdef FETCH_MISALIGN_TRAP_EN
                trap_pend = (target_addr[1:0] != 2'b00);
                trap_pc   = target_addr;
                next_pc   = target_addr;
`else
                trap_pend = 0;
                next_pc   = {target_addr[31:2], 2'b00};
`endif
            end
        end
        cyc++;
    end

    // Driver
    int p_rdy = 100;
    int p_rsp = 100;
    int p_ifr = 100;

    task automatic drive(input bit rst, input bit sel, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        reset          = rst;
        pc_sel         = sel;
        target_addr    = tgt;
        imem_req_ready = ($urandom_range(99) < p_rdy);
        if_ready       = ($urandom_range(99) < p_ifr);
        if (rst) begin
            imem_rsp_valid = $urandom_range(1) == 1;
            imem_rsp_data  = $urandom;
        end else if (inflight.size() > 0 && $urandom_range(99) < p_rsp) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(inflight[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    task automatic run(input int n);
        repeat (n) drive(0, 0, 32'd0);
    endtask

    task automatic do_reset();
        repeat (3) drive(1, 0, 32'd0);
    endtask

    task automatic wait_inflight(input int n);
        for (int i = 0; i < 20 && inflight.size() != n; i++) run(1);
        check("wait_inflight", inflight.size(), n);
    endtask

    initial begin
        int rel;
        logic [31:0] tgt;

        // Sequential fetch from RESET_PC with a 1-cycle memory.
        p_rdy = 100; p_rsp = 100; p_ifr = 100;
        do_reset();
        clear_logs();
        drive(0, 0, 32'd0);
        rel = cyc;
        run(9);
        check("seq_acc0", acc_log[0], 32'h100);
        check("seq_acc1", acc_log[1], 32'h104);
        check("seq_acc2", acc_log[2], 32'h108);
        check("seq_pres0", pres_log[0], 32'h100);
        check("seq_pres1", pres_log[1], 32'h104);
        check("seq_pres2", pres_log[2], 32'h108);
        check("boot_first_acc_cycle", acc_cyc[0] - rel, 32'd1);
        check("rsp_to_pop_latency", pres_cyc[0] - acc_cyc[0], 32'd2);

        // Decode stalls: buffer fills to two, requests stop, nothing lost or duplicated.
        p_ifr = 0;
        run(5);
        check("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("stall_if_valid", {31'd0, if_valid}, 32'd1);
        clear_logs();
        p_ifr = 100;
        run(10);
        check("stall_resume_cnt", {31'd0, pres_log.size() >= 6}, 32'd1);
        for (int i = 1; i < pres_log.size(); i++) begin
            check("stall_seq", pres_log[i], pres_log[i-1] + 32'd4);
        end

        // Two stale requests in flight at redirect.
        do_reset();
        p_rsp = 0;
        drive(0, 0, 32'd0);
        wait_inflight(2);
        drive(0, 1, 32'h200);
        p_rsp = 100;
        run(10);
        check("redir_pres0", pres_log[0], 32'h200);
        check("redir_pres1", pres_log[1], 32'h204);

        // Redirect coinciding with a response and a request acceptance.
        do_reset();
        p_rsp = 0;
        drive(0, 0, 32'd0);
        wait_inflight(1);
        p_rsp = 100;
        drive(0, 1, 32'h300);
        drive(0, 0, 32'd0);
        check("coinc_flush_req", {31'd0, imem_req_valid}, 32'd0);
        check("coinc_flush_ifv", {31'd0, if_valid}, 32'd0);
        run(8);
        check("coinc_pres0", pres_log[0], 32'h300);

        // Address wrap.
        drive(0, 1, 32'hFFFF_FFFC);
        run(8);
        check("wrap_cnt", {31'd0, acc_log.size() >= 2}, 32'd1);
        check("wrap_acc0", acc_log[0], 32'hFFFF_FFFC);
        check("wrap_acc1", acc_log[1], 32'h0000_0000);

        // Misaligned target.
        drive(0, 1, 32'h202);
        run(8);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("trap_pres_pc", pres_log[0], 32'h202);
        check("trap_pres_mis", {31'd0, pres_mis[0]}, 32'd1);
        check("trap_pres_instr", pres_instr[0], 32'h13);
        run(6);
        check("trap_idle_no_req", acc_log.size(), 32'd0);
        drive(0, 1, 32'h400);
        run(6);
        check("trap_exit_acc0", acc_log[0], 32'h400);
`else
        check("mis_acc0", acc_log[0], 32'h200);
        check("mis_pres0", pres_log[0], 32'h200);
        check("mis_flag0", {31'd0, pres_mis[0]}, 32'd0);
`endif

        // Randomized traffic, redirects and occasional mid-run resets.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                p_rdy = $urandom_range(100, 30);
                p_rsp = $urandom_range(100, 30);
                p_ifr = $urandom_range(100, 0);
            end
            if ($urandom_range(399) == 0) begin
                drive(1, 0, 32'd0);
                drive(1, 0, 32'd0);
            end else if ($urandom_range(99) < 4) begin
                tgt = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
                if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
`endif
                drive(0, 1, tgt);
            end else begin
                drive(0, 0, 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port pc_sel  input  1  redirect request from the branch controller (taken branch or jump).
REQ-005 SHALL have port target_addr  input  32  redirect destination, sampled when pc_sel=1.
REQ-006 SHALL have port imem_req_valid  output  1  instruction-memory request valid.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 SHALL have port imem_addr  output  32  request word address.
REQ-009 SHALL have port imem_rsp_valid  input  1  response valid; responses return in order, at least 1 cycle after acceptance.
REQ-010 SHALL have port imem_rsp_data  input  32  response instruction word.
REQ-011 SHALL have port if_valid  output  1  an instruction is presented to decode.
REQ-012 SHALL have port if_ready  input  1  decode accepts the presented instruction.
REQ-013 SHALL have ports if_pc  output  32 and if_instr  output  32  PC and instruction of the presented entry.
REQ-014 SHALL have port if_misalign  output  1  the presented entry is a misaligned-target trap marker.

Function
REQ-015 SHALL hold a PC register pc_q; a request is accepted when imem_req_valid && imem_req_ready, imem_addr = pc_q, and pc_q increments by 4 on acceptance (32-bit wrap, 32'hFFFF_FFFC -> 0).
REQ-016 SHALL implement a 2-entry in-order buffer {pc, instr}; responses are written on imem_rsp_valid, and the head is popped when if_valid && if_ready.
REQ-017 SHALL keep at most 2 requests in flight; imem_req_valid = (state == RUN) && (outstanding + buffered < 2).
REQ-018 SHALL drive if_valid = buffer non-empty, if_pc/if_instr = head entry, and hold them stable while if_valid && !if_ready.
REQ-019 SHALL implement states BOOT, RUN and FLUSH; BOOT lasts exactly one cycle after reset deasserts with no request, then the state moves to RUN.
REQ-020 When pc_sel=1, SHALL load pc_q <= target_addr, empty the buffer, set drop_cnt = in-flight count (including a request accepted that same cycle), and enter FLUSH if drop_cnt > 0, else stay in RUN.
REQ-021 In FLUSH, SHALL discard responses and decrement drop_cnt per response, issue no requests, and return to RUN when drop_cnt reaches 0.
REQ-022 SHALL give redirect priority over everything: a response or a pop in the same cycle as pc_sel=1 is discarded, and a pc_sel=1 in FLUSH re-targets pc_q and keeps the accumulated drop_cnt.
REQ-023 SHALL allow a simultaneous push and pop while full without loss.
REQ-024 SHALL never present an entry whose request preceded the latest redirect.
REQ-025 SHALL give a latency of exactly 1 cycle from response to if_valid, when the buffer was empty.

Reset
REQ-026 While reset=1, SHALL set pc_q=RESET_PC, buffer empty, outstanding=0, drop_cnt=0, state=BOOT, imem_req_valid=0, if_valid=0, if_misalign=0, if_pc=0, if_instr=0.
REQ-027 Reset asserted mid-operation SHALL abandon in-flight requests; responses arriving during reset are ignored.

Configuration
REQ-028 With FETCH_MISALIGN_TRAP_EN defined, a redirect with target_addr[1:0]!=0 SHALL enter state TRAP after the drain.
REQ-029 In TRAP, SHALL issue no requests and present one entry: if_valid=1, if_misalign=1, if_pc=target_addr, if_instr=32'h0000_0013, held until accepted.
REQ-030 After the TRAP entry is accepted, SHALL stay idle until the next pc_sel=1.
REQ-031 Without FETCH_MISALIGN_TRAP_EN, SHALL force target_addr[1:0] to 2'b00 on load, and if_misalign SHALL be tied to 0.

Verification
REQ-032 Reset release, RESET_PC=0x100, ready=1, 1-cycle memory -> requests 0x100, 0x104, 0x108..., and if_pc matches in order.
REQ-033 if_ready=0 for 5 cycles -> at most 2 buffered, imem_req_valid=0 when full, no entry lost or duplicated.
REQ-034 Two requests in flight, pc_sel=1, target=0x200 -> both stale responses dropped, next if_pc=0x200, then 0x204.
REQ-035 pc_sel=1 in the same cycle as imem_rsp_valid and a request acceptance -> response dropped, accepted request counted in drop_cnt, no stale if_valid.
REQ-036 With the macro, target=0x202 -> if_misalign=1, if_pc=0x202, if_instr=0x13, then no requests until the next redirect; without the macro -> fetch from 0x200.
REQ-037 pc_q=0xFFFF_FFFC with 2 requests accepted -> second address is 0x0000_0000.
